// File: rtl/dma_xfer_ctrl.sv
// dma_xfer_ctrl: word-by-word memory-to-memory copy sequencer (req/gnt master).
// Optional level interrupt on completion is built in when DMA_IRQ_EN is defined.
module dma_xfer_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  start,
    input  logic                  irq_enable,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  irq,
    input  logic                  irq_clear,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_gnt,
    input  logic                  rd_rvalid,
    input  logic [DATA_WIDTH-1:0] rd_rdata,
    output logic                  wr_req,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_gnt
);
    localparam int STEP = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] A_STEP = ADDR_WIDTH'(STEP);
    localparam logic [ADDR_WIDTH-1:0] A_MASK = ADDR_WIDTH'(STEP - 1);
    localparam logic [LEN_WIDTH-1:0]  L_STEP = LEN_WIDTH'(STEP);
    localparam logic [LEN_WIDTH-1:0]  L_MASK = LEN_WIDTH'(STEP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_FIN
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur_src, cur_dst;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  accept, misaligned, last_beat, fin_entry;

    assign accept     = (state == S_IDLE) && start;
    assign misaligned = ((src_addr & A_MASK) != '0) ||
                        ((dst_addr & A_MASK) != '0) ||
                        ((length & L_MASK) != '0);
    assign last_beat  = (remaining == L_STEP);
    assign fin_entry  = (state_nxt == S_FIN);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Zero-length and misaligned requests both finish without bus traffic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:
                if (start)
                    state_nxt = (length == '0 || misaligned) ? S_FIN : S_RD_REQ;
            S_RD_REQ:  if (rd_gnt)    state_nxt = S_RD_WAIT;
            S_RD_WAIT: if (rd_rvalid) state_nxt = S_WR_REQ;
            S_WR_REQ:
                if (wr_gnt)
                    state_nxt = last_beat ? S_FIN : S_RD_REQ;
            S_FIN:     state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        rd_req = 1'b0;
        wr_req = 1'b0;
        unique case (state)
            S_RD_REQ:  begin busy = 1'b1; rd_req = 1'b1; end
            S_RD_WAIT: busy = 1'b1;
            S_WR_REQ:  begin busy = 1'b1; wr_req = 1'b1; end
            default:   ;
        endcase
    end

    assign rd_addr = cur_src;
    assign wr_addr = cur_dst;
    assign wr_data = data_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cur_src   <= '0;
            cur_dst   <= '0;
            remaining <= '0;
            data_q    <= '0;
        end else begin
            if (accept) begin
                cur_src   <= src_addr;
                cur_dst   <= dst_addr;
                remaining <= length;
            end
            if (state == S_RD_WAIT && rd_rvalid)
                data_q <= rd_rdata;
            if (state == S_WR_REQ && wr_gnt) begin
                cur_src   <= cur_src + A_STEP;
                cur_dst   <= cur_dst + A_STEP;
                remaining <= remaining - L_STEP;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            if (fin_entry)   done <= 1'b1;
            else if (accept) done <= 1'b0;
            if (accept)
                error <= (length != '0) && misaligned;
        end
    end

`ifdef DMA_IRQ_EN
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)                     irq <= 1'b0;
        else if (irq_clear)               irq <= 1'b0;
        else if (fin_entry && irq_enable) irq <= 1'b1;
    end
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = irq_clear ^ irq_enable;
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// tb_dma_xfer_ctrl: vector table plus random transfers against a behavioural copy model.
// Define DMA_IRQ_EN for both files to exercise the interrupt path.
module tb_dma_xfer_ctrl;
    logic        ACLK, ARESETn;
    logic        start, irq_enable, irq_clear;
    logic [31:0] src_addr, dst_addr, length;
    logic        busy, done, error, irq;
    logic        rd_req, rd_gnt, rd_rvalid;
    logic [31:0] rd_addr, rd_rdata;
    logic        wr_req, wr_gnt;
    logic [31:0] wr_addr, wr_data;

    int n_vec  = 0;
    int n_miss = 0;

    localparam int LIMIT = 500;

    typedef struct {
        logic [31:0] s, d, l;
        int          gd, vd, wd, poke;
        bit          poke_fin;
        bit          exp_err;
        int          exp_beats;
    } xfer_t;

    dma_xfer_ctrl dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .start(start), .irq_enable(irq_enable),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done), .error(error), .irq(irq), .irq_clear(irq_clear),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic void ref_model(input logic [31:0] s, d, l,
                                      output bit err, output int beats);
        if (l == 0) begin
            err = 1'b0; beats = 0;
        end else if (((s | d | l) & 32'd3) != 0) begin
            err = 1'b1; beats = 0;
        end else begin
            err = 1'b0; beats = int'(l / 4);
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; rd_gnt = 1'b0; wr_gnt = 1'b0;
        rd_rvalid = 1'b0; rd_rdata = '0; irq_clear = 1'b0;
    endtask

    task automatic run_xfer(input string tag, input xfer_t v);
        int          cyc, rd_cnt, wr_cnt, rv_cnt, done_cyc, exp_cyc;
        logic [31:0] rv_a;
        logic [31:0] q_ra[$], q_wa[$], q_wd[$];
        bit          busy_ok, stab_ok, excl_ok;
        cyc = 0; rd_cnt = 0; wr_cnt = 0; rv_cnt = 0; done_cyc = 0;
        rv_a = '0; busy_ok = 1; stab_ok = 1; excl_ok = 1;
        @(negedge ACLK);
        start = 1'b1; src_addr = v.s; dst_addr = v.d; length = v.l;
        while (done_cyc == 0 && cyc < LIMIT) begin
            @(negedge ACLK);
            cyc++;
            start = (cyc == v.poke);
            src_addr = $urandom; dst_addr = $urandom; length = $urandom;
            rd_gnt = 1'b0; wr_gnt = 1'b0; rd_rvalid = 1'b0; rd_rdata = $urandom;
            if (rd_req && wr_req) excl_ok = 0;
            if (done) begin
                done_cyc = cyc;
                start = v.poke_fin;
                if (busy) busy_ok = 0;
            end else if (!busy) busy_ok = 0;
            if (rd_req) begin
                if (rd_cnt == 0) q_ra.push_back(rd_addr);
                else if (rd_addr !== q_ra[$]) stab_ok = 0;
                if (rd_cnt == v.gd) begin
                    rd_gnt = 1'b1; rd_cnt = 0; rv_cnt = v.vd; rv_a = rd_addr;
                end else begin
                    rd_cnt++;
                    rd_rvalid = 1'($urandom_range(0, 1));
                end
            end else if (wr_req) begin
                if (wr_cnt == 0) begin
                    q_wa.push_back(wr_addr); q_wd.push_back(wr_data);
                end else if (wr_addr !== q_wa[$] || wr_data !== q_wd[$])
                    stab_ok = 0;
                if (wr_cnt == v.wd) begin
                    wr_gnt = 1'b1; wr_cnt = 0;
                end else begin
                    wr_cnt++;
                    rd_rvalid = 1'($urandom_range(0, 1));
                end
            end else if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    rd_rvalid = 1'b1; rd_rdata = memval(rv_a);
                end
            end
        end
        check({tag, " done_seen"}, 32'(done_cyc != 0), 32'd1);
        @(negedge ACLK);
        idle_inputs();
        exp_cyc = (v.exp_beats == 0) ? 1 : v.exp_beats * (v.gd + v.vd + v.wd + 2) + 1;
        check({tag, " latency"}, done_cyc, exp_cyc);
        check({tag, " error"}, 32'(error), 32'(v.exp_err));
        check({tag, " done_sticky"}, 32'(done), 32'd1);
        check({tag, " idle_after"}, {29'd0, busy, rd_req, wr_req}, 32'd0);
        check({tag, " busy_profile"}, 32'(busy_ok), 32'd1);
        check({tag, " req_stable"}, 32'(stab_ok), 32'd1);
        check({tag, " req_exclusive"}, 32'(excl_ok), 32'd1);
        check({tag, " n_reads"}, q_ra.size(), v.exp_beats);
        check({tag, " n_writes"}, q_wa.size(), v.exp_beats);
        for (int i = 0; i < v.exp_beats && i < q_ra.size() && i < q_wa.size(); i++) begin
            check($sformatf("%s rd_addr[%0d]", tag, i), q_ra[i], v.s + 32'(4 * i));
            check($sformatf("%s wr_addr[%0d]", tag, i), q_wa[i], v.d + 32'(4 * i));
            check($sformatf("%s wr_data[%0d]", tag, i), q_wd[i], memval(v.s + 32'(4 * i)));
        end
    endtask

    xfer_t vecs[8];
    xfer_t rv;

    initial begin
        vecs[0] = '{32'h100, 32'h200, 32'd4, 0, 1, 0, 0, 1'b0, 1'b0, 1};
        vecs[1] = '{32'h100, 32'h200, 32'd16, 3, 2, 1, 5, 1'b0, 1'b0, 4};
        vecs[2] = '{32'h100, 32'h200, 32'd0, 0, 1, 0, 0, 1'b1, 1'b0, 0};
        vecs[3] = '{32'h102, 32'h200, 32'd4, 0, 1, 0, 0, 1'b0, 1'b1, 0};
        vecs[4] = '{32'h100, 32'h200, 32'd6, 0, 1, 0, 0, 1'b1, 1'b1, 0};
        vecs[5] = '{32'h100, 32'h203, 32'd8, 0, 1, 0, 0, 1'b0, 1'b1, 0};
        vecs[6] = '{32'hFFFF_FFFC, 32'h10, 32'd8, 1, 1, 0, 3, 1'b1, 1'b0, 2};
        vecs[7] = '{32'h40, 32'hFFFF_FFF8, 32'd12, 0, 3, 2, 0, 1'b0, 1'b0, 3};

        ARESETn = 1'b0; irq_enable = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0;
        idle_inputs();
        repeat (3) @(negedge ACLK);
        check("reset_outputs",
              {26'd0, busy, done, error, irq, rd_req, wr_req}, 32'd0);
        check("reset_addr", rd_addr | wr_addr | wr_data, 32'd0);
        ARESETn = 1'b1;

        for (int i = 0; i < 8; i++)
            run_xfer($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 20; i++) begin
            rv.s = $urandom; rv.d = $urandom;
            if ($urandom_range(0, 9) != 0) rv.s[1:0] = 2'b00;
            if ($urandom_range(0, 9) != 0) rv.d[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) rv.s = 32'hFFFF_FFF0 | (rv.s & 32'd3);
            rv.l = 32'(4 * $urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) rv.l = rv.l + 32'd2;
            rv.gd = $urandom_range(0, 3); rv.vd = $urandom_range(1, 3);
            rv.wd = $urandom_range(0, 3); rv.poke = $urandom_range(2, 6);
            rv.poke_fin = 1'($urandom_range(0, 1));
            ref_model(rv.s, rv.d, rv.l, rv.exp_err, rv.exp_beats);
            run_xfer($sformatf("rnd%0d", i), rv);
        end

        // reset while a write is pending must drop everything at once
        @(negedge ACLK);
        start = 1'b1; src_addr = 32'h300; dst_addr = 32'h400; length = 32'd4;
        for (int c = 0; c < 30 && !wr_req; c++) begin
            @(negedge ACLK);
            start = 1'b0;
            rd_gnt = rd_req;
            rd_rvalid = busy && !rd_req && !wr_req;
            rd_rdata = 32'hCAFE_0001;
        end
        check("rst_wr_req_reached", 32'(wr_req), 32'd1);
        idle_inputs();
        ARESETn = 1'b0;
        #1;
        check("rst_async_outputs",
              {26'd0, busy, done, error, irq, rd_req, wr_req}, 32'd0);
        check("rst_async_addr", rd_addr | wr_addr | wr_data, 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        repeat (3) @(negedge ACLK);
        check("rst_no_resume", {29'd0, busy, rd_req, wr_req}, 32'd0);

        irq_enable = 1'b1;
        run_xfer("irq_on", vecs[0]);
`ifdef DMA_IRQ_EN
        check("irq_set", 32'(irq), 32'd1);
        irq_clear = 1'b1;
        @(negedge ACLK);
        irq_clear = 1'b0;
        check("irq_cleared", 32'(irq), 32'd0);
        irq_enable = 1'b0;
        run_xfer("irq_off", vecs[0]);
        check("irq_disabled", 32'(irq), 32'd0);
`else
        check("irq_tied_low", 32'(irq), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
